// File: rtl/rv32i_id_decode.sv
// RV32I instruction-decode stage.
// Holds the 32x32 register file (x0 hard-wired to zero) with a write-first
// bypass from write-back, decodes the immediate format, rd write-enable and
// illegal-instruction flag, and registers everything for EX with a fixed
// one-cycle latency and no stall.
module rv32i_id_decode #(
    parameter logic [31:0] NOP_IW = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iw_in,
    input  logic [31:0] pc_in,
    input  logic        wb_enable,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] rs1_data_out,
    output logic [31:0] rs2_data_out,
    output logic [31:0] imm_out,
    output logic [4:0]  rd_out,
    output logic        wb_enable_out,
    output logic        illegal_out
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } imm_fmt_t;

    logic [31:0] regs [32];

    logic [6:0]  opcode;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;
    imm_fmt_t    fmt;
    logic        no_rd_write;
    logic [31:0] imm_next;
    logic        wb_en_next;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    assign opcode  = iw_in[6:0];
    assign rs1_idx = iw_in[19:15];
    assign rs2_idx = iw_in[24:20];
    assign rd_idx  = iw_in[11:7];

    // Register file write port; reset wipes every entry, x0 is never written.
    // NOTE: the register file needs an asynchronous clear, so it is built from
    // flops rather than a RAM macro, which cannot be reset in one step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_enable && wb_reg != 5'd0) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            regs[wb_reg] <= wb_data;
        end
    end

    // Operand read with write-first bypass from the same-cycle write-back.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_idx != 5'd0) begin
            rs1_val = (wb_enable && wb_reg == rs1_idx) ? wb_data : regs[rs1_idx];
        end
        if (rs2_idx != 5'd0) begin
            rs2_val = (wb_enable && wb_reg == rs2_idx) ? wb_data : regs[rs2_idx];
        end
    end

    // Opcode to immediate format, and whether the opcode never writes rd.
    always_comb begin
        fmt         = FMT_ILL;
        no_rd_write = 1'b0;
        unique case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_SYSTEM: begin
                fmt         = FMT_I;
                no_rd_write = 1'b1;
            end
            OP_STORE: begin
                fmt         = FMT_S;
                no_rd_write = 1'b1;
            end
            OP_BRANCH: begin
                fmt         = FMT_B;
                no_rd_write = 1'b1;
            end
            OP_LUI, OP_AUIPC: fmt = FMT_U;
            OP_JAL:           fmt = FMT_J;
            OP_REG:           fmt = FMT_R;
            default:          fmt = FMT_ILL;
        endcase
    end

    // Immediate assembly and rd write-enable from the decoded format.
    always_comb begin
        imm_next = '0;
        unique case (fmt)
            FMT_I: imm_next = {{20{iw_in[31]}}, iw_in[31:20]};
            FMT_S: imm_next = {{20{iw_in[31]}}, iw_in[31:25], iw_in[11:7]};
            FMT_B: imm_next = {{19{iw_in[31]}}, iw_in[31], iw_in[7],
                               iw_in[30:25], iw_in[11:8], 1'b0};
            FMT_U: imm_next = {iw_in[31:12], 12'b0};
            FMT_J: imm_next = {{11{iw_in[31]}}, iw_in[31], iw_in[19:12],
                               iw_in[20], iw_in[30:21], 1'b0};
            default: imm_next = '0;
        endcase
        wb_en_next = (fmt != FMT_ILL) && !no_rd_write && (rd_idx != 5'd0);
    end

    // ID/EX pipeline register; a new instruction is captured every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out        <= '0;
            iw_out        <= NOP_IW;
            rs1_data_out  <= '0;
            rs2_data_out  <= '0;
            imm_out       <= '0;
            rd_out        <= '0;
            wb_enable_out <= 1'b0;
            illegal_out   <= 1'b0;
        end else begin
            pc_out        <= pc_in;
            iw_out        <= iw_in;
            rs1_data_out  <= rs1_val;
            rs2_data_out  <= rs2_val;
            imm_out       <= imm_next;
            rd_out        <= rd_idx;
            wb_enable_out <= wb_en_next;
            illegal_out   <= (fmt == FMT_ILL);
        end
    end

endmodule

// File: tb/tb_rv32i_id_decode.sv
// Self-checking bench for rv32i_id_decode: directed scenarios plus randomized
// traffic compared against a behavioural model of the decode stage.
module tb_rv32i_id_decode;

    logic        clk;
    logic        reset;
    logic [31:0] iw_in;
    logic [31:0] pc_in;
    logic        wb_enable;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic [31:0] pc_out;
    logic [31:0] iw_out;
    logic [31:0] rs1_data_out;
    logic [31:0] rs2_data_out;
    logic [31:0] imm_out;
    logic [4:0]  rd_out;
    logic        wb_enable_out;
    logic        illegal_out;

    int checks = 0;
    int errors = 0;

    rv32i_id_decode #(.NOP_IW(32'h0000_0013)) dut (
        .clk          (clk),
        .reset        (reset),
        .iw_in        (iw_in),
        .pc_in        (pc_in),
        .wb_enable    (wb_enable),
        .wb_reg       (wb_reg),
        .wb_data      (wb_data),
        .pc_out       (pc_out),
        .iw_out       (iw_out),
        .rs1_data_out (rs1_data_out),
        .rs2_data_out (rs2_data_out),
        .imm_out      (imm_out),
        .rd_out       (rd_out),
        .wb_enable_out(wb_enable_out),
        .illegal_out  (illegal_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state and the expectation for the last applied cycle.
    logic [31:0] model_regs [32];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] iw;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t exp_out;

    function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                               input logic [4:0] wr, input logic [31:0] wd);
        if (idx == 5'd0) return 32'd0;
        if (we && wr == idx) return wd;
        return model_regs[idx];
    endfunction

    // Immediate / writes-rd / illegal straight from the RV32I encoding rules.
    function automatic void model_decode(input logic [31:0] iw, output logic [31:0] imm,
                                         output logic we, output logic ill);
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        i12 = iw[31:20];
        s12 = {iw[31:25], iw[11:7]};
        b13 = {iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
        j21 = {iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
        imm = 32'd0;
        we  = 1'b0;
        ill = 1'b0;
        case (iw[6:0])
            7'h13, 7'h03, 7'h67: begin imm = 32'(i12); we = 1'b1; end
            7'h73:               imm = 32'(i12);
            7'h23:               imm = 32'(s12);
            7'h63:               imm = 32'(b13);
            7'h37, 7'h17: begin  imm = iw & 32'hFFFF_F000; we = 1'b1; end
            7'h6F: begin         imm = 32'(j21); we = 1'b1; end
            7'h33:               we = 1'b1;
            default:             ill = 1'b1;
        endcase
        if (iw[11:7] == 5'd0) we = 1'b0;
    endfunction

    // Drive one cycle, build the expectation, and sample #1 after the edge.
    task automatic apply(input logic [31:0] iw, input logic [31:0] pc, input logic we,
                         input logic [4:0] wr, input logic [31:0] wd);
        iw_in     = iw;
        pc_in     = pc;
        wb_enable = we;
        wb_reg    = wr;
        wb_data   = wd;
        exp_out.pc  = pc;
        exp_out.iw  = iw;
        exp_out.rs1 = model_read(iw[19:15], we, wr, wd);
        exp_out.rs2 = model_read(iw[24:20], we, wr, wd);
        exp_out.rd  = iw[11:7];
        model_decode(iw, exp_out.imm, exp_out.we, exp_out.ill);
        @(posedge clk);
        #1;
        if (we && wr != 5'd0) model_regs[wr] = wd;
        wb_enable = 1'b0;
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b0, rd, 7'h33};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        iw_in = 32'h00A0_0093;
        pc_in = 32'h1000;
        wb_enable = 1'b0;
        wb_reg = 5'd0;
        wb_data = 32'd0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        @(posedge clk);
        #1;
        checks++;
        if (iw_out !== 32'h0000_0013 || pc_out !== 32'd0 || rs1_data_out !== 32'd0 ||
            rs2_data_out !== 32'd0 || imm_out !== 32'd0 || rd_out !== 5'd0 ||
            wb_enable_out !== 1'b0 || illegal_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got iw=%h pc=%h rs1=%h rs2=%h imm=%h rd=%0d we=%b ill=%b, expected iw=00000013 rest 0",
                     iw_out, pc_out, rs1_data_out, rs2_data_out, imm_out, rd_out,
                     wb_enable_out, illegal_out);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_wb_then_read();
        apply(32'h0000_0013, 32'h100, 1'b1, 5'd5, 32'hDEAD_BEEF);
        apply(32'hFFF2_8313, 32'h104, 1'b0, 5'd0, 32'd0);
        checks++;
        if (rs1_data_out !== 32'hDEAD_BEEF || imm_out !== 32'hFFFF_FFFF ||
            rd_out !== 5'd6 || wb_enable_out !== 1'b1) begin
            errors++;
            $display("FAIL addi_x6_x5: got rs1=%h imm=%h rd=%0d we=%b, expected deadbeef ffffffff 6 1",
                     rs1_data_out, imm_out, rd_out, wb_enable_out);
        end
        checks++;
        if (pc_out !== 32'h104 || iw_out !== 32'hFFF2_8313) begin
            errors++;
            $display("FAIL addi_passthru: got pc=%h iw=%h, expected 00000104 fff28313", pc_out, iw_out);
        end
    endtask

    task automatic test_bypass();
        apply(32'h0073_80B3, 32'h200, 1'b1, 5'd7, 32'h1234_5678);
        checks++;
        if (rs1_data_out !== 32'h1234_5678 || rs2_data_out !== 32'h1234_5678) begin
            errors++;
            $display("FAIL bypass_x7: got rs1=%h rs2=%h, expected 12345678 12345678",
                     rs1_data_out, rs2_data_out);
        end
        // The bypassed value must also have landed in the register file.
        apply(r_type(5'd2, 5'd7, 5'd0), 32'h204, 1'b0, 5'd0, 32'd0);
        checks++;
        if (rs1_data_out !== 32'h1234_5678 || rs2_data_out !== 32'd0) begin
            errors++;
            $display("FAIL x7_stored: got rs1=%h rs2=%h, expected 12345678 00000000",
                     rs1_data_out, rs2_data_out);
        end
    endtask

    task automatic test_x0();
        apply(32'h0000_0013, 32'h300, 1'b1, 5'd0, 32'hFFFF_FFFF);
        apply(r_type(5'd3, 5'd0, 5'd0), 32'h304, 1'b0, 5'd0, 32'd0);
        checks++;
        if (rs1_data_out !== 32'd0) begin
            errors++;
            $display("FAIL x0_after_write: got rs1=%h, expected 00000000", rs1_data_out);
        end
        // Write to x0 in the same cycle as a read of x0.
        apply(r_type(5'd3, 5'd0, 5'd0), 32'h308, 1'b1, 5'd0, 32'hFFFF_FFFF);
        checks++;
        if (rs1_data_out !== 32'd0 || rs2_data_out !== 32'd0) begin
            errors++;
            $display("FAIL x0_same_cycle: got rs1=%h rs2=%h, expected 0 0", rs1_data_out, rs2_data_out);
        end
    endtask

    task automatic test_imm_formats();
        apply(32'hFE00_0EE3, 32'h400, 1'b0, 5'd0, 32'd0);
        checks++;
        if (imm_out !== 32'hFFFF_FFFC || wb_enable_out !== 1'b0 || illegal_out !== 1'b0) begin
            errors++;
            $display("FAIL beq_imm: got imm=%h we=%b ill=%b, expected fffffffc 0 0",
                     imm_out, wb_enable_out, illegal_out);
        end
        apply(32'h0010_00EF, 32'h404, 1'b0, 5'd0, 32'd0);
        checks++;
        if (imm_out !== 32'h0000_0800 || wb_enable_out !== 1'b1 || rd_out !== 5'd1) begin
            errors++;
            $display("FAIL jal_imm: got imm=%h we=%b rd=%0d, expected 00000800 1 1",
                     imm_out, wb_enable_out, rd_out);
        end
        // LUI x0: U immediate but rd=0 suppresses write-back.
        apply(32'hABCD_E037, 32'h408, 1'b0, 5'd0, 32'd0);
        checks++;
        if (imm_out !== 32'hABCD_E000 || wb_enable_out !== 1'b0) begin
            errors++;
            $display("FAIL lui_x0: got imm=%h we=%b, expected abcde000 0", imm_out, wb_enable_out);
        end
    endtask

    task automatic test_illegal();
        apply(32'hFFFF_FFFF, 32'h500, 1'b0, 5'd0, 32'd0);
        checks++;
        if (illegal_out !== 1'b1 || wb_enable_out !== 1'b0 || imm_out !== 32'd0 ||
            iw_out !== 32'hFFFF_FFFF || rd_out !== 5'd31) begin
            errors++;
            $display("FAIL illegal_ffff: got ill=%b we=%b imm=%h iw=%h rd=%0d, expected 1 0 0 ffffffff 31",
                     illegal_out, wb_enable_out, imm_out, iw_out, rd_out);
        end
        apply(32'h0000_0093 & 32'hFFFF_FFFC, 32'h504, 1'b0, 5'd0, 32'd0);
        checks++;
        if (illegal_out !== 1'b1 || wb_enable_out !== 1'b0) begin
            errors++;
            $display("FAIL illegal_lowbits: got ill=%b we=%b, expected 1 0", illegal_out, wb_enable_out);
        end
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [31:0] iw;
        logic        we;
        logic [4:0]  wr;
        int          k;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        for (int n = 0; n < 300; n++) begin
            iw = $urandom();
            k  = $urandom_range(0, 11);
            if (k < 10) iw[6:0] = ops[k];
            else if (k == 10) iw[6:0] = 7'h0F;
            else iw[1:0] = 2'b00;
            we = ($urandom_range(0, 3) != 0);
            wr = ($urandom_range(0, 2) == 0) ? iw[19:15] :
                 ($urandom_range(0, 2) == 0) ? iw[24:20] : 5'($urandom_range(0, 31));
            apply(iw, $urandom(), we, wr, $urandom());
            checks++;
            if (pc_out !== exp_out.pc || iw_out !== exp_out.iw || rd_out !== exp_out.rd) begin
                errors++;
                $display("FAIL rand%0d_pass: got pc=%h iw=%h rd=%0d, expected %h %h %0d",
                         n, pc_out, iw_out, rd_out, exp_out.pc, exp_out.iw, exp_out.rd);
            end
            checks++;
            if (rs1_data_out !== exp_out.rs1 || rs2_data_out !== exp_out.rs2) begin
                errors++;
                $display("FAIL rand%0d_operands: got rs1=%h rs2=%h, expected %h %h",
                         n, rs1_data_out, rs2_data_out, exp_out.rs1, exp_out.rs2);
            end
            checks++;
            if (imm_out !== exp_out.imm || wb_enable_out !== exp_out.we ||
                illegal_out !== exp_out.ill) begin
                errors++;
                $display("FAIL rand%0d_decode iw=%h: got imm=%h we=%b ill=%b, expected %h %b %b",
                         n, iw, imm_out, wb_enable_out, illegal_out,
                         exp_out.imm, exp_out.we, exp_out.ill);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int r = 1; r < 32; r++) begin
            apply(32'h0000_0013, 32'h600, 1'b1, 5'(r), 32'hA500_0000 | 32'(r));
        end
        apply(32'h0010_00EF, 32'h604, 1'b0, 5'd0, 32'd0);
        // Assert reset between edges together with a pending write-back.
        #3;
        reset     = 1'b1;
        wb_enable = 1'b1;
        wb_reg    = 5'd9;
        wb_data   = 32'hCAFE_F00D;
        #1;
        checks++;
        if (iw_out !== 32'h0000_0013 || pc_out !== 32'd0 || imm_out !== 32'd0 ||
            rd_out !== 5'd0 || wb_enable_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got iw=%h pc=%h imm=%h rd=%0d we=%b, expected 00000013 0 0 0 0",
                     iw_out, pc_out, imm_out, rd_out, wb_enable_out);
        end
        @(posedge clk);
        #1;
        checks++;
        if (iw_out !== 32'h0000_0013 || rs1_data_out !== 32'd0 || illegal_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got iw=%h rs1=%h ill=%b, expected 00000013 0 0",
                     iw_out, rs1_data_out, illegal_out);
        end
        @(negedge clk);
        reset     = 1'b0;
        wb_enable = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        #1;
        checks++;
        if (iw_out !== 32'h0000_0013) begin
            errors++;
            $display("FAIL post_reset_nop: got iw=%h, expected 00000013", iw_out);
        end
        for (int r = 1; r < 32; r++) begin
            apply(r_type(5'd4, 5'(r), 5'(32 - r)), 32'h700, 1'b0, 5'd0, 32'd0);
            checks++;
            if (rs1_data_out !== 32'd0 || rs2_data_out !== 32'd0) begin
                errors++;
                $display("FAIL cleared_x%0d: got rs1=%h rs2=%h, expected 0 0",
                         r, rs1_data_out, rs2_data_out);
            end
        end
        checks++;
        if (iw_out !== r_type(5'd4, 5'd31, 5'd1)) begin
            errors++;
            $display("FAIL post_reset_capture: got iw=%h, expected %h", iw_out, r_type(5'd4, 5'd31, 5'd1));
        end
    endtask

    initial begin
        test_reset();
        test_wb_then_read();
        test_bypass();
        test_x0();
        test_imm_formats();
        test_illegal();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32i_id_decode.md
RV32I_ID_DECODE -- requirements
Module: rv32i_id_decode

Interface
REQ-001 SHALL have parameter NOP_IW, default 32'h0000_0013 (ADDI x0,x0,0), the instruction word driven on iw_out while in reset.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port iw_in  input  32  instruction word from fetch stage.
REQ-005 SHALL have port pc_in  input  32  PC of iw_in from fetch stage.
REQ-006 SHALL have port wb_enable  input  1  write-back strobe from WB stage.
REQ-007 SHALL have port wb_reg  input  5  write-back destination register index.
REQ-008 SHALL have port wb_data  input  32  write-back data.
REQ-009 SHALL have port pc_out  output  32  registered PC to EX.
REQ-010 SHALL have port iw_out  output  32  registered instruction word to EX.
REQ-011 SHALL have port rs1_data_out  output  32  registered rs1 operand.
REQ-012 SHALL have port rs2_data_out  output  32  registered rs2 operand.
REQ-013 SHALL have port imm_out  output  32  registered sign-extended immediate.
REQ-014 SHALL have port rd_out  output  5  registered destination index (iw_in[11:7]).
REQ-015 SHALL have port wb_enable_out  output  1  registered "instruction writes rd".
REQ-016 SHALL have port illegal_out  output  1  registered illegal-instruction flag.

Function
REQ-017 SHALL contain a 32x32 register file; x0 reads 0 always, writes to x0 ignored.
REQ-018 SHALL write wb_data to regfile[wb_reg] on posedge clk when wb_enable=1 and wb_reg!=0.
REQ-019 SHALL read rs1=iw_in[19:15], rs2=iw_in[24:20] combinationally; when wb_enable=1, wb_reg!=0 and wb_reg equals the read index, SHALL return wb_data (write-first bypass), same cycle.
REQ-020 SHALL register all outputs on posedge clk: latency exactly 1 cycle from iw_in/pc_in to outputs; no stall, new instruction accepted every cycle.
REQ-021 SHALL decode opcode iw_in[6:0] to immediate format: I for 0010011, 0000011, 1100111, 1110011; S for 0100011; B for 1100011; U for 0110111, 0010111; J for 1101111; R (0110011) imm=0.
REQ-022 SHALL form immediates per RV32I: I={20{iw[31]},iw[31:20]}; S={20{iw[31]},iw[31:25],iw[11:7]}; B={19{iw[31]},iw[31],iw[7],iw[30:25],iw[11:8],1'b0}; U={iw[31:12],12'b0}; J={11{iw[31]},iw[31],iw[19:12],iw[20],iw[30:21],1'b0}.
REQ-023 SHALL set wb_enable_out=1 only for R, I-ALU, load, JALR, LUI, AUIPC, JAL with rd!=0; 0 for S, B, SYSTEM, illegal, or rd=0.
REQ-024 SHALL set illegal_out=1 when iw_in[1:0]!=2'b11 or opcode not in REQ-021 list; then imm_out=0, wb_enable_out=0, other outputs pass through.
REQ-025 Simultaneous write-back and read of same register SHALL yield the new value (REQ-019); write-back to x0 with matching read SHALL yield 0.

Reset
REQ-026 On reset assertion SHALL asynchronously clear regfile x1..x31 to 0, pc_out=0, iw_out=NOP_IW, rs1/rs2_data_out=0, imm_out=0, rd_out=0, wb_enable_out=0, illegal_out=0.
REQ-027 Reset asserted mid-operation SHALL discard any same-edge write-back; outputs hold reset values while reset=1; first post-reset posedge captures iw_in normally.

Verification
REQ-028 Reset, then wb x5<=32'hDEAD_BEEF; next cycle iw_in=ADDI x6,x5,-1 (32'hFFF28313) -> rs1_data_out=32'hDEAD_BEEF, imm_out=32'hFFFF_FFFF, rd_out=6, wb_enable_out=1.
REQ-029 Same cycle wb_enable=1, wb_reg=7, wb_data=32'h1234_5678 with iw_in=ADD x1,x7,x7 (32'h007380B3) -> rs1_data_out=rs2_data_out=32'h1234_5678.
REQ-030 wb x0<=32'hFFFF_FFFF, then iw_in reads x0 -> rs1_data_out=0.
REQ-031 iw_in=BEQ with imm -4 (32'hFE000EE3) -> imm_out=32'hFFFF_FFFC, wb_enable_out=0; iw_in=JAL x1,+2048 (32'h001000EF) -> imm_out=32'h0000_0800.
REQ-032 iw_in=32'hFFFF_FFFF -> illegal_out=1, wb_enable_out=0, imm_out=0.
REQ-033 Assert reset between edges after loading x1..x31 -> outputs reset values immediately; after release all registers read 0, iw_out=32'h0000_0013 until first capture.
